// File: rtl/floor_scroller.sv
// Floor renderer for the dino game: a solid floor line plus a dashed ground
// texture that scrolls left by a programmable number of pixels per frame.
// Pixel queries are answered with a fixed one-cycle latency. The current
// scroll offset and the floor row are exported for collision and spawning.
module floor_scroller #(
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int XW          = 9,
    parameter int YW          = 8,
    parameter int FLOOR_Y     = 100,
    parameter int FLOOR_THICK = 2,
    parameter int TEX_PERIOD  = 16,
    parameter int SPEED_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               game_over,
    input  logic [SPEED_W-1:0] speed,
    input  logic               q_valid,
    input  logic [XW-1:0]      q_x,
    input  logic [YW-1:0]      q_y,
    output logic               r_valid,
    output logic               r_pixel,
    output logic [YW-1:0]      floor_y,
    output logic [XW-1:0]      scroll_x,
    output logic [1:0]         state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PAUSED  = 2'd2;
    localparam logic [1:0] STOPPED = 2'd3;

    // Comparisons are done one bit wider so a full-range screen size still fits.
    localparam logic [XW:0]   LP_SCREEN_W = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]   LP_SCREEN_H = (YW+1)'(SCREEN_H);
    localparam logic [YW-1:0] LP_SOLID_LO = YW'(FLOOR_Y);
    localparam logic [YW-1:0] LP_SOLID_HI = YW'(FLOOR_Y + FLOOR_THICK - 1);
    localparam logic [YW-1:0] LP_TEX_ROW  = YW'(FLOOR_Y + FLOOR_THICK + 2);
    // TEX_PERIOD is a power of two, so "mod TEX_PERIOD" is just a low-bit mask.
    localparam logic [XW-1:0] LP_TEX_MASK = XW'(TEX_PERIOD - 1);
    localparam logic [XW-1:0] LP_TEX_HALF = XW'(TEX_PERIOD / 2);

    logic [1:0]    r_state;
    logic [XW-1:0] r_scroll;

    logic [XW:0]   w_step_sum;
    logic [XW-1:0] w_step_next;
    logic [XW:0]   w_tex_sum;
    logic [XW-1:0] w_tex_x;
    logic          w_in_range;
    logic          w_solid;
    logic          w_texture;
    logic          w_hit;

    assign floor_y  = YW'(FLOOR_Y);
    assign scroll_x = r_scroll;
    assign state    = r_state;

    // Next scroll offset after one frame; speed < SCREEN_W so one wrap suffices.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_step_next = r_scroll;
        w_step_sum  = {1'b0, r_scroll} + (XW+1)'(speed);
        if (w_step_sum >= LP_SCREEN_W) begin
            w_step_next = XW'(w_step_sum - LP_SCREEN_W);
        end else begin
            w_step_next = XW'(w_step_sum);
        end
    end

    // Texture column seen by the query: (q_x + scroll) wrapped at the screen edge.
    // Only in-range q_x matters, so the sum stays below 2*SCREEN_W and one wrap is enough.
    always_comb begin
        w_tex_x   = '0;
        w_tex_sum = {1'b0, q_x} + {1'b0, r_scroll};
        if (w_tex_sum >= LP_SCREEN_W) begin
            w_tex_x = XW'(w_tex_sum - LP_SCREEN_W);
        end else begin
            w_tex_x = XW'(w_tex_sum);
        end
    end

    assign w_in_range = ({1'b0, q_x} < LP_SCREEN_W) && ({1'b0, q_y} < LP_SCREEN_H);
    assign w_solid    = (q_y >= LP_SOLID_LO) && (q_y <= LP_SOLID_HI);
    assign w_texture  = (q_y == LP_TEX_ROW) && ((w_tex_x & LP_TEX_MASK) < LP_TEX_HALF);
    assign w_hit      = w_in_range && (w_solid || w_texture);

    // Game-state FSM and scroll offset; game_over beats pause beats frame_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state  <= IDLE;
            r_scroll <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_scroll <= '0;
                    end
                end
                RUN: begin
                    if (game_over) begin
                        r_state <= STOPPED;
                    end else if (pause) begin
                        r_state <= PAUSED;
                    end else if (frame_tick) begin
                        r_scroll <= w_step_next;
                    end
                end
                PAUSED: begin
                    if (game_over) begin
                        r_state <= STOPPED;
                    end else if (!pause) begin
                        r_state <= RUN;
                    end
                end
                STOPPED: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_scroll <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // One-cycle query pipeline; reset drops any query in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_pixel <= 1'b0;
        end else begin
            r_valid <= q_valid;
            r_pixel <= q_valid && w_hit;
        end
    end

endmodule
